ad7321_slave_emu: RTL and testbench

AD7321_SLAVE_EMU -- requirements
Module: ad7321_slave_emu

---
 rtl/ad7321_slave_emu.sv | 178 +++++++++++++++++
 tb/tb_ad7321_slave_emu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad7321_slave_emu.sv
// AD7321 SPI slave emulator: returns a sampled channel word to the master and
// latches control/range writes. Define AD7321_EMU_CODING_EN for straight-binary coding.
module ad7321_slave_emu #(
    parameter int U_DLY = 1
) (
    input  logic        clk,
    input  logic        syn_rst,
    input  logic        sclk,
    input  logic        csn,
    input  logic        mosi,
    output logic        miso,
    input  logic [12:0] chn0_dat,
    input  logic [12:0] chn1_dat,
    output logic        cfg_add0,
    output logic [1:0]  cfg_vin0_range,
    output logic [1:0]  cfg_vin1_range,
    output logic        cfg_coding,
    output logic        frame_vld,
    output logic [15:0] frame_dat,
    output logic        frame_err
);

    // state    | meaning
    // IDLE     | csn high, waiting for a csn falling edge
    // SHIFT    | frame in progress, shifting mosi in and tx_word out
    // WAIT_CSN | after reset, waiting for csn high before accepting a frame
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_CSN = 2'd2
    } state_t;

    // The delay parameter is kept for instantiation compatibility; the model carries no delays.
    logic unused_dly;
    assign unused_dly = (U_DLY != 0);

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  sclk_sync;
    logic [2:0]  csn_sync;
    logic [1:0]  mosi_sync;

    logic        sclk_rise;
    logic        sclk_fall;
    logic        csn_rise;
    logic        csn_fall;
    logic        csn_s;
    logic        mosi_s;

    logic        start;
    logic        finish;

    logic [12:0] sample;
    logic [15:0] tx_word;
    logic [14:0] tx_rem;
    logic [15:0] rx_sh;
    logic [4:0]  bit_cnt;

    // Synchronisers track the pins through reset so csn is seen correctly on release.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[1:0], sclk};
        csn_sync  <= {csn_sync[1:0], csn};
        mosi_sync <= {mosi_sync[0], mosi};
    end

    assign csn_s     = csn_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign csn_rise  = csn_sync[1] & ~csn_sync[2];
    assign csn_fall  = ~csn_sync[1] & csn_sync[2];

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state <= WAIT_CSN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_nxt = SHIFT;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            WAIT_CSN: begin
                if (csn_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = WAIT_CSN;
        endcase
    end

    always_comb begin
        sample = cfg_add0 ? chn1_dat : chn0_dat;
`ifdef AD7321_EMU_CODING_EN
        if (cfg_coding) begin
            sample[12] = ~sample[12];
        end
`endif
        tx_word = {1'b0, cfg_add0, sample, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            miso           <= 1'b0;
            tx_rem         <= '0;
            rx_sh          <= '0;
            bit_cnt        <= '0;
            frame_vld      <= 1'b0;
            frame_err      <= 1'b0;
            frame_dat      <= '0;
            cfg_add0       <= 1'b0;
            cfg_coding     <= 1'b0;
            cfg_vin0_range <= '0;
            cfg_vin1_range <= '0;
        end else begin
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                // The sample is frozen here; channel changes during the frame are not seen.
                miso    <= tx_word[15];
                tx_rem  <= tx_word[14:0];
                rx_sh   <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (finish) begin
                    miso <= 1'b0;
                    if (bit_cnt == 5'd16) begin
                        frame_vld <= 1'b1;
                        frame_dat <= rx_sh;
                        if (rx_sh[15]) begin
                            case (rx_sh[14:13])
                                2'b00: begin
                                    cfg_add0   <= rx_sh[12];
                                    cfg_coding <= rx_sh[7];
                                end
                                2'b01: begin
                                    cfg_vin0_range <= rx_sh[12:11];
                                    cfg_vin1_range <= rx_sh[8:7];
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else if (sclk_rise && bit_cnt != 5'd16) begin
                    rx_sh   <= {rx_sh[14:0], mosi_s};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        miso <= 1'b0;
                    end
                end else if (sclk_fall) begin
                    miso   <= (bit_cnt == 5'd16) ? 1'b0 : tx_rem[14];
                    tx_rem <= {tx_rem[13:0], 1'b0};
                end
            end else begin
                miso <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad7321_slave_emu.sv
// Self-checking bench for ad7321_slave_emu: directed frames plus randomized frames
// checked against a frame-level model of the register map and readback word.
module tb_ad7321_slave_emu;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        syn_rst;
    logic        sclk;
    logic        csn;
    logic        mosi;
    logic        miso;
    logic [12:0] chn0_dat;
    logic [12:0] chn1_dat;
    logic        cfg_add0;
    logic [1:0]  cfg_vin0_range;
    logic [1:0]  cfg_vin1_range;
    logic        cfg_coding;
    logic        frame_vld;
    logic [15:0] frame_dat;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    logic        m_add0;
    logic        m_coding;
    logic [1:0]  m_r0;
    logic [1:0]  m_r1;
    logic [15:0] m_fd;

    ad7321_slave_emu dut (
        .clk            (clk),
        .syn_rst        (syn_rst),
        .sclk           (sclk),
        .csn            (csn),
        .mosi           (mosi),
        .miso           (miso),
        .chn0_dat       (chn0_dat),
        .chn1_dat       (chn1_dat),
        .cfg_add0       (cfg_add0),
        .cfg_vin0_range (cfg_vin0_range),
        .cfg_vin1_range (cfg_vin1_range),
        .cfg_coding     (cfg_coding),
        .frame_vld      (frame_vld),
        .frame_dat      (frame_dat),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // Pulses are counted per clk cycle, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (frame_vld === 1'b1) vld_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag);
        check({tag, ":frame_dat"}, {16'h0, frame_dat}, {16'h0, m_fd});
        check({tag, ":add0"}, {31'h0, cfg_add0}, {31'h0, m_add0});
        check({tag, ":coding"}, {31'h0, cfg_coding}, {31'h0, m_coding});
        check({tag, ":vin0"}, {30'h0, cfg_vin0_range}, {30'h0, m_r0});
        check({tag, ":vin1"}, {30'h0, cfg_vin1_range}, {30'h0, m_r1});
    endtask

    // Master side: mosi changes with sclk low, miso is sampled just before each rising edge.
    task automatic spi_xfer(input logic [15:0] word, input int nclk, output logic [31:0] rd);
        rd  = '0;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            mosi = (i < 16) ? word[15 - i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            rd   = {rd[30:0], miso};
            sclk = 1'b1;
            if (i == 5) begin
                chn0_dat = 13'($urandom);
                chn1_dat = 13'($urandom);
            end
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_frame(input logic [15:0] word, input int nclk, input string tag,
                            output logic [31:0] rd);
        logic [12:0] s;
        logic [15:0] tx;
        logic [31:0] exp_rd;
        int          v0;
        int          e0;
        s = m_add0 ? chn1_dat : chn0_dat;
`ifdef AD7321_EMU_CODING_EN
        if (m_coding) s = s ^ 13'h1000;
`endif
        tx = {1'b0, m_add0, s, 1'b0};
        exp_rd = '0;
        for (int i = 0; i < nclk; i++) begin
            exp_rd = {exp_rd[30:0], (i < 16) ? tx[15 - i] : 1'b0};
        end
        v0 = vld_cnt;
        e0 = err_cnt;
        spi_xfer(word, nclk, rd);
        if (nclk >= 16) begin
            m_fd = word;
            if (word[15]) begin
                if (word[14:13] == 2'd0) begin
                    m_add0   = word[12];
                    m_coding = word[7];
                end else if (word[14:13] == 2'd1) begin
                    m_r0 = word[12:11];
                    m_r1 = word[8:7];
                end
            end
        end
        check({tag, ":miso"}, rd, exp_rd);
        check({tag, ":vld_pulses"}, 32'(vld_cnt - v0), (nclk >= 16) ? 32'd1 : 32'd0);
        check({tag, ":err_pulses"}, 32'(err_cnt - e0), (nclk >= 16) ? 32'd0 : 32'd1);
        check_cfg(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] w;
        int          n;
        int          v0;
        int          e0;

        syn_rst  = 1'b1;
        sclk     = 1'b0;
        csn      = 1'b1;
        mosi     = 1'b0;
        chn0_dat = '0;
        chn1_dat = '0;
        m_add0   = 1'b0;
        m_coding = 1'b0;
        m_r0     = '0;
        m_r1     = '0;
        m_fd     = '0;
        repeat (6) @(negedge clk);
        check("rst:miso", {31'h0, miso}, 32'h0);
        check("rst:vld", {31'h0, frame_vld}, 32'h0);
        check("rst:err", {31'h0, frame_err}, 32'h0);
        check_cfg("rst");
        syn_rst = 1'b0;
        repeat (6) @(negedge clk);

        // Read-only frame on channel 0: {0,0,0x1ABC,0}.
        chn0_dat = 13'h1ABC;
        do_frame(16'h0123, 16, "chn0_read", rd);
        check("chn0_read:word", rd, 32'h3578);

        // 0xB180 is a range write; bits[12:11]=2'b10 go to VIN0, bits[8:7]=2'b11 to VIN1.
        do_frame(16'hB180, 16, "range_wr", rd);
        check("range_wr:dat", {16'h0, frame_dat}, 32'hB180);
        check("range_wr:vin1", {30'h0, cfg_vin1_range}, 32'h3);

        // ADD0=1 takes effect one frame later.
        chn0_dat = 13'h0A5A;
        chn1_dat = 13'h0005;
        do_frame(16'h9000, 16, "add0_wr", rd);
        check("add0_wr:word", rd, {16'h0, 3'b000, 13'h0A5A, 1'b0} >> 1 << 1);
        chn1_dat = 13'h0005;
        do_frame(16'h0000, 16, "add0_next", rd);
        check("add0_next:word", rd, 32'h400A);

        // Aborted frames leave configuration and frame_dat alone.
        do_frame(16'h8000, 9, "abort9", rd);
        do_frame(16'hA000, 20, "sclk20", rd);
        check("sclk20:tail", {28'h0, rd[3:0]}, 32'h0);

        // Reset in the middle of a frame with csn held low.
        v0 = vld_cnt;
        e0 = err_cnt;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                syn_rst = 1'b1;
                repeat (4) @(negedge clk);
                syn_rst  = 1'b0;
                m_add0   = 1'b0;
                m_coding = 1'b0;
                m_r0     = '0;
                m_r1     = '0;
                m_fd     = '0;
            end
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i >= 8) check("midrst:miso", {31'h0, miso}, 32'h0);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst:vld_pulses", 32'(vld_cnt - v0), 32'd0);
        check("midrst:err_pulses", 32'(err_cnt - e0), 32'd0);
        check_cfg("midrst");
        chn0_dat = 13'h1ABC;
        do_frame(16'hB180, 16, "post_rst", rd);
        check("post_rst:word", rd, 32'h3578);

        for (int k = 0; k < 14; k++) begin
            w        = 16'($urandom);
            n        = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
            chn0_dat = 13'($urandom);
            chn1_dat = 13'($urandom);
            do_frame(w, n, "rand", rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
